// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bundle of the branch predict unit: IF lookup, EX resolve/update, statistics.
// ex_branch is the EX-stage valid; ex_stall holds EX, so an update is taken only on an edge with ex_branch=1 and ex_stall=0.
interface branch_predict_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  pred_taken;
    logic                  ex_branch;
    logic                  ex_stall;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic [2:0]            ex_funct3;
    logic                  ex_eq;
    logic                  ex_lt;
    logic                  ex_ltu;
    logic                  ex_pred_taken;
    logic                  take_branch;
    logic                  mispredict;
    logic [STAT_WIDTH-1:0] stat_branches;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    modport master (
        output if_pc, ex_branch, ex_stall, ex_pc, ex_funct3, ex_eq, ex_lt, ex_ltu, ex_pred_taken,
        input  pred_taken, take_branch, mispredict, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_branch, ex_stall, ex_pc, ex_funct3, ex_eq, ex_lt, ex_ltu, ex_pred_taken,
        output pred_taken, take_branch, mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predict_unit.sv
// EX branch resolution plus a PC-indexed table of saturating counters predicting for IF,
// with mispredict flagging and wrapping branch/mispredict statistics.
module branch_predict_unit #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef logic [PC_WIDTH-1:0] pc_t;

    // Word-aligned PCs: the low two bits never select an entry.
    function automatic logic [INDEX_BITS-1:0] pc_index(input pc_t pc);
        return pc[INDEX_BITS+1:2];
    endfunction

    logic [CTR_BITS-1:0]   bht [ENTRIES];
    logic [STAT_WIDTH-1:0] stat_branches;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    logic                  funct3_valid;
    logic                  take_branch;
    logic                  mispredict;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_next;

    always_comb begin
        take_branch = 1'b0;
        case (bus.ex_funct3)
            3'b000:  take_branch = bus.ex_eq;
            3'b001:  take_branch = ~bus.ex_eq;
            3'b100:  take_branch = bus.ex_lt;
            3'b101:  take_branch = ~bus.ex_lt;
            3'b110:  take_branch = bus.ex_ltu;
            3'b111:  take_branch = ~bus.ex_ltu;
            default: take_branch = 1'b0;
        endcase
        take_branch = take_branch & bus.ex_branch;
    end

    // An invalid funct3 still raises mispredict when IF guessed taken, so the pipeline refetches.
    assign mispredict   = bus.ex_branch & (take_branch ^ bus.ex_pred_taken);
    assign funct3_valid = (bus.ex_funct3[2:1] != 2'b01);
    assign update_valid = bus.ex_branch & ~bus.ex_stall & funct3_valid;

    always_comb begin
        ex_idx   = pc_index(bus.ex_pc);
        ctr_cur  = bht[ex_idx];
        ctr_next = ctr_cur;
        if (take_branch) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (update_valid) begin
            bht[ex_idx]   <= ctr_next;
            stat_branches <= stat_branches + STAT_WIDTH'(1);
            if (mispredict) stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
        end
    end

    // Read of the registered table only: an update this cycle shows up after the edge.
    assign bus.pred_taken       = bht[pc_index(bus.if_pc)][CTR_BITS-1];
    assign bus.take_branch      = take_branch;
    assign bus.mispredict       = mispredict;
    assign bus.stat_branches    = stat_branches;
    assign bus.stat_mispredicts = stat_mispredicts;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized checks of branch_predict_unit against a table-of-integers model.
module tb_branch_predict_unit;
  localparam int PW = 32;
  localparam int IB = 6;
  localparam int CB = 2;
  localparam int SW = 4;
  localparam int NE = 64;
  localparam int CMAX = 3;
  localparam int CINIT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_WIDTH(PW), .STAT_WIDTH(SW)) bus ();

  branch_predict_unit #(
    .PC_WIDTH(PW), .INDEX_BITS(IB), .CTR_BITS(CB), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int m_bht[NE];
  int m_br;
  int m_mis;
  int checks = 0;
  int errors = 0;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[idx(pc)] >= (CMAX + 1) / 2;
  endfunction

  function automatic bit m_valid_f3(input logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  function automatic bit m_take();
    bit r;
    r = 1'b0;
    if (bus.ex_branch) begin
      case (bus.ex_funct3)
        3'd0: r = bus.ex_eq;
        3'd1: r = !bus.ex_eq;
        3'd4: r = bus.ex_lt;
        3'd5: r = !bus.ex_lt;
        3'd6: r = bus.ex_ltu;
        3'd7: r = !bus.ex_ltu;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    bit t;
    bit mp;
    t  = m_take();
    mp = bus.ex_branch && (t != bus.ex_pred_taken);
    check({tag, "_take"}, 32'(bus.take_branch), 32'(t));
    check({tag, "_mis"}, 32'(bus.mispredict), 32'(mp));
    check({tag, "_pred"}, 32'(bus.pred_taken), 32'(m_pred(bus.if_pc)));
    check({tag, "_nbr"}, 32'(bus.stat_branches), 32'(m_br % 16));
    check({tag, "_nmis"}, 32'(bus.stat_mispredicts), 32'(m_mis % 16));
  endtask

  // Inputs are already driven; check combinational outputs, then advance one edge and update the model.
  task automatic cycle(input string tag);
    bit t;
    bit mp;
    bit v;
    int i;
    #1;
    check_comb(tag);
    t  = m_take();
    mp = bus.ex_branch && (t != bus.ex_pred_taken);
    v  = bus.ex_branch && !bus.ex_stall && m_valid_f3(bus.ex_funct3);
    i  = idx(bus.ex_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < NE; k++) m_bht[k] = CINIT;
      m_br  = 0;
      m_mis = 0;
    end else if (v) begin
      if (t) m_bht[i] = (m_bht[i] < CMAX) ? m_bht[i] + 1 : CMAX;
      else   m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
      m_br  = (m_br + 1) % 16;
      m_mis = (m_mis + (mp ? 1 : 0)) % 16;
    end
  endtask

  task automatic drive(input bit br, input bit st, input logic [31:0] pc, input logic [2:0] f3,
                       input bit eq, input bit lt, input bit ltu, input bit pt);
    bus.ex_branch     = br;
    bus.ex_stall      = st;
    bus.ex_pc         = pc;
    bus.ex_funct3     = f3;
    bus.ex_eq         = eq;
    bus.ex_lt         = lt;
    bus.ex_ltu        = ltu;
    bus.ex_pred_taken = pt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rst");
    rst = 1'b0;
  endtask

  logic [2:0] f3_list[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  bit exp_take6[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  bit exp_mis3[3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    for (int k = 0; k < NE; k++) m_bht[k] = CINIT;
    m_br = 0;
    m_mis = 0;
    rst = 1'b1;
    bus.if_pc = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: no PC predicts taken, statistics zero.
    for (int a = 0; a < 64; a++) begin
      bus.if_pc = 32'(a * 4);
      #1;
      check("reset_pred", 32'(bus.pred_taken), 32'd0);
    end
    check("reset_nbr", 32'(bus.stat_branches), 32'd0);
    check("reset_nmis", 32'(bus.stat_mispredicts), 32'd0);

    // BEQ taken three times at 0x40: counter climbs and saturates.
    bus.if_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h40, 3'd0, 1, 0, 0, m_pred(32'h40));
      #1;
      check("beq_take", 32'(bus.take_branch), 32'd1);
      check("beq_mis", 32'(bus.mispredict), 32'(exp_mis3[k]));
      cycle("beq");
      check("beq_pred_after", 32'(bus.pred_taken), 32'd1);
    end
    check("beq_ctr", 32'(m_bht[16]), 32'd3);
    check("beq_nbr", 32'(bus.stat_branches), 32'd3);
    check("beq_nmis", 32'(bus.stat_mispredicts), 32'd1);

    // All valid funct3 with eq=0, lt=1, ltu=0.
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 32'h200 + 32'(k * 4), f3_list[k], 0, 1, 0, 0);
      #1;
      check("f3_take", 32'(bus.take_branch), 32'(exp_take6[k]));
      cycle("f3");
    end

    // Invalid funct3 predicted taken: mispredict raised, no state change.
    drive(1, 0, 32'h40, 3'd2, 1, 1, 1, 1);
    #1;
    check("inv_take", 32'(bus.take_branch), 32'd0);
    check("inv_mis", 32'(bus.mispredict), 32'd1);
    cycle("inv");

    // Same-cycle read/write at 0x80 from a fresh 01 entry.
    do_reset();
    bus.if_pc = 32'h80;
    drive(1, 0, 32'h80, 3'd0, 1, 0, 0, 0);
    #1;
    check("rw_pred_now", 32'(bus.pred_taken), 32'd0);
    cycle("rw");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rw_pred_next", 32'(bus.pred_taken), 32'd1);

    // Stalled taken BNE: outcome visible, nothing committed.
    bus.if_pc = 32'h44;
    drive(1, 1, 32'h44, 3'd1, 0, 0, 0, 0);
    #1;
    check("stall_take", 32'(bus.take_branch), 32'd1);
    cycle("stall");
    check("stall_nbr", 32'(bus.stat_branches), 32'd1);
    check("stall_pred", 32'(bus.pred_taken), 32'd0);

    // Reset wins over a simultaneous valid update.
    rst = 1'b1;
    bus.if_pc = 32'h80;
    drive(1, 0, 32'h80, 3'd0, 1, 0, 0, 0);
    cycle("rst_upd");
    rst = 1'b0;
    check("rst_upd_pred", 32'(bus.pred_taken), 32'd0);
    check("rst_upd_nbr", 32'(bus.stat_branches), 32'd0);

    // Aliasing: 0x0 and 0x100 share an entry.
    bus.if_pc = 32'h100;
    drive(1, 0, 32'h0, 3'd0, 1, 0, 0, 0);
    cycle("alias0");
    drive(1, 0, 32'h100, 3'd0, 1, 0, 0, 1);
    cycle("alias1");
    check("alias_ctr", 32'(m_bht[0]), 32'd3);
    check("alias_pred", 32'(bus.pred_taken), 32'd1);

    // 17 valid branches wrap a 4-bit statistics counter to 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, 0, 32'(k * 4), 3'd0, 0, 0, 0, 0);
      cycle("wrap");
    end
    check("wrap_nbr", 32'(bus.stat_branches), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] epc;
      rst = ($urandom_range(0, 49) == 0);
      epc = 32'($urandom_range(0, 255)) << 2;
      bus.if_pc = ($urandom_range(0, 3) == 0) ? epc : (32'($urandom_range(0, 255)) << 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, epc, 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(epc));
      cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor of the combinational branch-decision logic.
- Resolves conditional branches in EX from funct3 and comparator flags, as before.
- Adds a PC-indexed branch history table (BHT) of saturating counters that gives IF a taken/not-taken prediction.
- Flags mispredictions for the pipeline flush and keeps branch and mispredict statistics counters.

Parameters:
- PC_WIDTH, 32: width of PC inputs.
- INDEX_BITS, 6: BHT index width; table has 2^INDEX_BITS entries.
- CTR_BITS, 2: saturating counter width per entry (≥1).
- STAT_WIDTH, 32: width of statistics counters.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  PC_WIDTH  fetch PC used for lookup.
- pred_taken  output  1  prediction for if_pc (combinational read).
- ex_branch  input  1  EX holds a conditional branch.
- ex_stall  input  1  EX frozen this cycle; no state updates.
- ex_pc  input  PC_WIDTH  PC of the EX branch.
- ex_funct3  input  3  branch funct3.
- ex_eq  input  1  rs1 == rs2.
- ex_lt  input  1  rs1 < rs2, signed.
- ex_ltu  input  1  rs1 < rs2, unsigned.
- ex_pred_taken  input  1  prediction made for this branch at IF, piped down.
- take_branch  output  1  resolved outcome (combinational).
- mispredict  output  1  resolved outcome differs from ex_pred_taken (combinational).
- stat_branches  output  STAT_WIDTH  count of resolved valid branches.
- stat_mispredicts  output  STAT_WIDTH  count of mispredicted valid branches.

Behaviour:
- Index: idx(pc) = pc[INDEX_BITS+1:2]. Bits [1:0] are ignored; aliasing is allowed.
- Prediction:
  - pred_taken = MSB of BHT[idx(if_pc)].
  - Combinational, zero latency.
  - Reflects table state as of the last clock edge. There is no write-to-read bypass: same-cycle update of the same index is visible next cycle.
- Resolution (combinational) when ex_branch=1:
  - BEQ 000 → eq.
  - BNE 001 → ~eq.
  - BLT 100 → lt.
  - BGE 101 → ~lt.
  - BLTU 110 → ltu.
  - BGEU 111 → ~ltu.
  - 010/011 are invalid: take_branch=0.
  - When ex_branch=0: take_branch=0 and mispredict=0.
- mispredict = ex_branch & (take_branch ^ ex_pred_taken).
  - Also asserted for an invalid funct3 with ex_pred_taken=1, so the pipeline recovers.
- Update is "valid" when ex_branch=1, ex_stall=0 and funct3 is valid. On the clock edge of a valid update:
  - BHT[idx(ex_pc)] increments if take_branch, saturating at 2^CTR_BITS-1.
  - It decrements if not taken, saturating at 0.
  - stat_branches += 1.
  - stat_mispredicts += 1 if mispredict.
- Invalid funct3 or ex_stall=1: table and statistics are unchanged. mispredict and take_branch still drive combinationally.
- Statistics counters wrap modulo 2^STAT_WIDTH; they do not saturate.
- Reset (rst=1 at an edge):
  - Every BHT entry is set to weakly-not-taken, value 2^(CTR_BITS-1)-1 (01 for 2-bit).
  - Both stat counters are cleared to 0.
  - Reset has priority over a simultaneous update.
  - During and after reset: pred_taken=0 for every PC, and the stats read 0.
  - take_branch/mispredict stay purely combinational from inputs, so they are not affected by reset.
- Reset mid-stream discards all history; the first post-reset update starts from 01.
- CTR_BITS=1: entry is a last-outcome bit; reset value 0.

Test Plan:
- Reset, then sweep if_pc 0x0..0xFC step 4 → pred_taken=0 everywhere; stat_branches=stat_mispredicts=0.
- BEQ at ex_pc=0x40, ex_eq=1, ex_pred_taken=0, 3 consecutive cycles:
  - Outcomes: take_branch=1, mispredict=1,0,0 (pred carried from pred_taken each time).
  - BHT[16] goes 01→10→11→11, saturating.
  - if_pc=0x40 reads pred_taken=1 after the first edge.
  - stat_branches=3, stat_mispredicts=1.
- All six funct3 values with (eq,lt,ltu) = (0,1,0) → take_branch = 0,1,1,0,0,1 respectively. funct3=010 with ex_pred_taken=1 → take_branch=0, mispredict=1, no BHT or stat change.
- Same-cycle read/write: if_pc=ex_pc=0x80, entry at 01, taken update → pred_taken=0 that cycle and 1 the next cycle.
- ex_stall=1 with a taken BNE → take_branch=1 but BHT and stats are unchanged. rst=1 concurrent with a valid update → all entries 01, stats 0.
- Aliasing and wrap:
  - ex_pc=0x0 and 0x100 (INDEX_BITS=6) update the same entry.
  - With STAT_WIDTH=4, 17 valid branches → stat_branches=1.
